// File: rtl/rs_encode_line_dispatch_if.sv
// Interface bundling the line dispatcher's stream and per-unit encoder handshakes.
// The master modport belongs to the dispatcher. The slave modport belongs to the
// environment: the line source and the encoder units.
// With RS_DISPATCH_PERF_EN defined, the interface also carries the two performance counters.
interface rs_encode_line_dispatch_if #(
  parameter int DATA_W       = 256,
  parameter int NUM_RS_UNITS = 4,
  parameter int UNIT_SEL_W   = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1
);
  logic                    src_dispatch_line_val;
  logic [DATA_W-1:0]       src_dispatch_line;
  logic                    dispatch_src_line_rdy;
  logic [NUM_RS_UNITS-1:0] dispatch_encoder_line_vals;
  logic [DATA_W-1:0]       dispatch_encoder_line;
  logic [NUM_RS_UNITS-1:0] encoder_dispatch_line_rdys;
  logic                    dispatch_block_done;
  logic [UNIT_SEL_W-1:0]   dispatch_unit_sel;
`ifdef RS_DISPATCH_PERF_EN
  logic [31:0]             dispatch_stall_cycles;
  logic [31:0]             dispatch_blocks_sent;

  modport master (
    input  src_dispatch_line_val, src_dispatch_line, encoder_dispatch_line_rdys,
    output dispatch_src_line_rdy, dispatch_encoder_line_vals, dispatch_encoder_line,
    output dispatch_block_done, dispatch_unit_sel,
    output dispatch_stall_cycles, dispatch_blocks_sent
  );

  modport slave (
    output src_dispatch_line_val, src_dispatch_line, encoder_dispatch_line_rdys,
    input  dispatch_src_line_rdy, dispatch_encoder_line_vals, dispatch_encoder_line,
    input  dispatch_block_done, dispatch_unit_sel,
    input  dispatch_stall_cycles, dispatch_blocks_sent
  );
`else
  modport master (
    input  src_dispatch_line_val, src_dispatch_line, encoder_dispatch_line_rdys,
    output dispatch_src_line_rdy, dispatch_encoder_line_vals, dispatch_encoder_line,
    output dispatch_block_done, dispatch_unit_sel
  );

  modport slave (
    output src_dispatch_line_val, src_dispatch_line, encoder_dispatch_line_rdys,
    input  dispatch_src_line_rdy, dispatch_encoder_line_vals, dispatch_encoder_line,
    input  dispatch_block_done, dispatch_unit_sel
  );
`endif
endinterface

// File: rtl/rs_encode_line_dispatch.sv
// Upstream stage of the multi-unit RS line encoder.
// It takes one val/rdy stream of lines and sends each block of NUM_LINES
// consecutive lines to one encoder unit. Units are used in strict round-robin order.
// Each line passes through a 2-entry skid buffer, and every entry carries its
// own {unit, last} tag. Because of this, a unit switch costs no bubble, and the
// input ready comes straight from a flop.
// The head of the buffer blocks the whole output: if the unit at the head
// stalls, every unit waits, and block order is preserved.
// Optional feature, enabled by defining RS_DISPATCH_PERF_EN: stall and
// blocks-sent performance counters.
module rs_encode_line_dispatch #(
  parameter int DATA_W       = 256,
  parameter int NUM_LINES    = 8,
  parameter int NUM_RS_UNITS = 4,
  parameter int UNIT_SEL_W   = (NUM_RS_UNITS > 1) ? $clog2(NUM_RS_UNITS) : 1,
  parameter int LINE_CNT_W   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  rs_encode_line_dispatch_if.master bus
);

  logic [DATA_W-1:0]     buf_data [2];
  logic [UNIT_SEL_W-1:0] buf_unit [2];
  logic [1:0]            buf_last;
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;
  logic [1:0]            count_nxt;

  logic [LINE_CNT_W-1:0] line_cnt;
  logic [UNIT_SEL_W-1:0] in_unit;
  logic                  rdy_q;
  logic                  done_q;

  logic                  push;
  logic                  pop;
  logic                  head_valid;
  logic [UNIT_SEL_W-1:0] head_unit;
  logic                  head_last;
  logic                  in_last;
  logic                  in_unit_last;

  assign head_valid   = (count != 2'd0);
  assign head_unit    = buf_unit[rd_ptr];
  assign head_last    = buf_last[rd_ptr];
  assign push         = bus.src_dispatch_line_val & rdy_q;
  // Only the ready of the unit named by the head tag matters.
  assign pop          = head_valid & bus.encoder_dispatch_line_rdys[head_unit];
  assign in_last      = (line_cnt == LINE_CNT_W'(NUM_LINES - 1));
  assign in_unit_last = (in_unit == UNIT_SEL_W'(NUM_RS_UNITS - 1));

  // Occupancy after this cycle's push/pop; it also feeds the registered ready.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 2'd1;
    end else if (pop && !push) begin
      count_nxt = count - 2'd1;
    end
  end

  // Skid buffer control, tags, registered ready and block-done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      rdy_q    <= 1'b0;
      done_q   <= 1'b0;
      buf_last <= 2'b00;
      buf_unit <= '{default: '0};
    end else begin
      count  <= count_nxt;
      rdy_q  <= (count_nxt < 2'd2);
      done_q <= pop & head_last;
      if (push) begin
        buf_unit[wr_ptr] <= in_unit;
        buf_last[wr_ptr] <= in_last;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Line payload storage. The data path is left unreset because the output is gated while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= bus.src_dispatch_line;
    end
  end

  // Input-side block tracking: line-in-block counter and round-robin unit pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cnt <= '0;
      in_unit  <= '0;
    end else if (push) begin
      if (in_last) begin
        line_cnt <= '0;
        in_unit  <= in_unit_last ? '0 : in_unit + UNIT_SEL_W'(1);
      end else begin
        line_cnt <= line_cnt + LINE_CNT_W'(1);
      end
    end
  end

  // Present the head entry to its unit; valids and data are zero while empty.
  always_comb begin
    bus.dispatch_encoder_line_vals = '0;
    bus.dispatch_encoder_line      = '0;
    if (head_valid) begin
      bus.dispatch_encoder_line_vals[head_unit] = 1'b1;
      bus.dispatch_encoder_line                 = buf_data[rd_ptr];
    end
  end

  assign bus.dispatch_src_line_rdy = rdy_q;
  assign bus.dispatch_block_done   = done_q;
  assign bus.dispatch_unit_sel     = in_unit;

`ifdef RS_DISPATCH_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] blocks_sent_q;

  // Stall counter saturates; the blocks-sent counter wraps at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      blocks_sent_q  <= 32'd0;
    end else begin
      if (head_valid && !pop && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (done_q) begin
        blocks_sent_q <= blocks_sent_q + 32'd1;
      end
    end
  end

  assign bus.dispatch_stall_cycles = stall_cycles_q;
  assign bus.dispatch_blocks_sent  = blocks_sent_q;
`endif

endmodule

// File: tb/tb_rs_encode_line_dispatch.sv
// Self-checking bench for rs_encode_line_dispatch.
// It builds three configurations: 4 lines x 2 units, 8 lines x 2 units, and 1 line x 3 units.
module tb_rs_encode_line_dispatch;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rs_encode_line_dispatch_if #(.DATA_W(DW), .NUM_RS_UNITS(2)) bus_a ();
  rs_encode_line_dispatch_if #(.DATA_W(DW), .NUM_RS_UNITS(2)) bus_b ();
  rs_encode_line_dispatch_if #(.DATA_W(DW), .NUM_RS_UNITS(3)) bus_c ();

  rs_encode_line_dispatch #(.DATA_W(DW), .NUM_LINES(4), .NUM_RS_UNITS(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.master));
  rs_encode_line_dispatch #(.DATA_W(DW), .NUM_LINES(8), .NUM_RS_UNITS(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.master));
  rs_encode_line_dispatch #(.DATA_W(DW), .NUM_LINES(1), .NUM_RS_UNITS(3)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c.master));

  typedef struct {
    logic          val;
    logic [DW-1:0] data;
    logic [1:0]    rdys;
    logic [1:0]    exp_vals;
    logic [DW-1:0] exp_line;
    logic          exp_done;
    logic          exp_rdy;
    logic          exp_sel;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus_a.src_dispatch_line_val = 1'b0; bus_a.src_dispatch_line = '0; bus_a.encoder_dispatch_line_rdys = '0;
    bus_b.src_dispatch_line_val = 1'b0; bus_b.src_dispatch_line = '0; bus_b.encoder_dispatch_line_rdys = '0;
    bus_c.src_dispatch_line_val = 1'b0; bus_c.src_dispatch_line = '0; bus_c.encoder_dispatch_line_rdys = '0;
  endtask

  // Reset, check the reset state, release, then return 1 ns after the first edge.
  task automatic reset_all();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 32'(bus_a.dispatch_src_line_rdy), 32'd0);
    chk("rst_vals", 32'(bus_a.dispatch_encoder_line_vals), 32'd0);
    chk("rst_line", 32'(bus_a.dispatch_encoder_line), 32'd0);
    chk("rst_done", 32'(bus_a.dispatch_block_done), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_done;
    int nxt;
    int acc;
    int popped;
    int cyc;
    int dones;
    logic prev_pop;
    logic exp_pop;
    logic exp_acc;
    logic [2:0] r;

    rst = 1'b1;
    idle_inputs();

    // Round-robin, throughput, tagging (4 lines x 2 units).
    for (int s = 0; s < 19; s++) begin
      vecs[s].val      = (s < 16);
      vecs[s].data     = DW'(s);
      vecs[s].rdys     = 2'b11;
      vecs[s].exp_vals = (s >= 1 && s <= 16) ? ((((s - 1) / 4) % 2) != 0 ? 2'b10 : 2'b01) : 2'b00;
      vecs[s].exp_line = (s >= 1) ? DW'(s - 1) : '0;
      vecs[s].exp_done = (s >= 2 && s <= 17 && ((s - 2) % 4) == 3);
      vecs[s].exp_rdy  = 1'b1;
      vecs[s].exp_sel  = ((((s < 16) ? s : 16) / 4) % 2) != 0;
    end

    reset_all();
    n_done = 0;
    for (int s = 0; s < 19; s++) begin
      bus_a.src_dispatch_line_val      = vecs[s].val;
      bus_a.src_dispatch_line          = vecs[s].data;
      bus_a.encoder_dispatch_line_rdys = vecs[s].rdys;
      @(negedge clk);
      chk($sformatf("a_vals[%0d]", s), 32'(bus_a.dispatch_encoder_line_vals), 32'(vecs[s].exp_vals));
      if (vecs[s].exp_vals != 2'b00)
        chk($sformatf("a_line[%0d]", s), bus_a.dispatch_encoder_line, vecs[s].exp_line);
      chk($sformatf("a_done[%0d]", s), 32'(bus_a.dispatch_block_done), 32'(vecs[s].exp_done));
      chk($sformatf("a_rdy[%0d]", s), 32'(bus_a.dispatch_src_line_rdy), 32'(vecs[s].exp_rdy));
      chk($sformatf("a_sel[%0d]", s), 32'(bus_a.dispatch_unit_sel), 32'(vecs[s].exp_sel));
      if (bus_a.dispatch_block_done) n_done++;
      @(posedge clk);
      #1;
    end
    chk("a_done_count", 32'(n_done), 32'd4);
`ifdef RS_DISPATCH_PERF_EN
    chk("a_blocks_sent", bus_a.dispatch_blocks_sent, 32'd4);
    chk("a_stall_zero", bus_a.dispatch_stall_cycles, 32'd0);
`endif

    // Head-of-line stall: unit 1 stalls while line 4 is at the head.
    reset_all();
    nxt = 0;
    for (int s = 0; s < 12; s++) begin
      bus_a.src_dispatch_line_val      = 1'b1;
      bus_a.src_dispatch_line          = DW'(nxt);
      bus_a.encoder_dispatch_line_rdys = (s >= 5 && s <= 8) ? 2'b01 : 2'b11;
      @(negedge clk);
      if (s >= 5 && s <= 9) begin
        chk($sformatf("stall_vals[%0d]", s), 32'(bus_a.dispatch_encoder_line_vals), 32'h2);
        chk($sformatf("stall_line[%0d]", s), bus_a.dispatch_encoder_line, 32'd4);
        chk($sformatf("stall_rdy[%0d]", s), 32'(bus_a.dispatch_src_line_rdy), (s == 5) ? 32'd1 : 32'd0);
      end
      if (s == 10 || s == 11) begin
        chk($sformatf("drain_vals[%0d]", s), 32'(bus_a.dispatch_encoder_line_vals), 32'h2);
        chk($sformatf("drain_line[%0d]", s), bus_a.dispatch_encoder_line, 32'(s - 5));
        chk($sformatf("drain_rdy[%0d]", s), 32'(bus_a.dispatch_src_line_rdy), 32'd1);
      end
      if (bus_a.dispatch_src_line_rdy) nxt++;
      @(posedge clk);
      #1;
    end

    // Ready isolation: unit 0 at the head is not ready; unit 1 ready must be ignored.
    reset_all();
    bus_a.src_dispatch_line_val      = 1'b1;
    bus_a.src_dispatch_line          = 32'hA0;
    bus_a.encoder_dispatch_line_rdys = 2'b10;
    @(posedge clk);
    #1;
    bus_a.src_dispatch_line_val = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      if (s == 6) bus_a.encoder_dispatch_line_rdys = 2'b11;
      @(negedge clk);
      chk($sformatf("iso_vals[%0d]", s), 32'(bus_a.dispatch_encoder_line_vals), 32'h1);
      chk($sformatf("iso_line[%0d]", s), bus_a.dispatch_encoder_line, 32'hA0);
`ifdef RS_DISPATCH_PERF_EN
      if (s == 6) chk("iso_stall_cycles", bus_a.dispatch_stall_cycles, 32'd5);
`endif
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("iso_popped_vals", 32'(bus_a.dispatch_encoder_line_vals), 32'h0);
    chk("iso_no_done", 32'(bus_a.dispatch_block_done), 32'd0);
    @(posedge clk);
    #1;

    // Async reset mid-block (8 lines x 2 units): 6 of 8 lines are accepted, then reset is asserted.
    reset_all();
    for (int s = 0; s < 6; s++) begin
      bus_b.src_dispatch_line_val      = 1'b1;
      bus_b.src_dispatch_line          = DW'(32'h100 + s);
      bus_b.encoder_dispatch_line_rdys = 2'b11;
      @(posedge clk);
      #1;
    end
    bus_b.src_dispatch_line_val = 1'b0;
    chk("b_pre_rst_vals", 32'(bus_b.dispatch_encoder_line_vals), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("b_rst_vals", 32'(bus_b.dispatch_encoder_line_vals), 32'h0);
    chk("b_rst_rdy", 32'(bus_b.dispatch_src_line_rdy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int s = 0; s < 8; s++) begin
      bus_b.src_dispatch_line_val = 1'b1;
      bus_b.src_dispatch_line     = DW'(32'h55 + s);
      @(negedge clk);
      chk($sformatf("b_sel[%0d]", s), 32'(bus_b.dispatch_unit_sel), 32'd0);
      chk($sformatf("b_rdy[%0d]", s), 32'(bus_b.dispatch_src_line_rdy), 32'd1);
      if (s == 1) begin
        chk("b_first_vals", 32'(bus_b.dispatch_encoder_line_vals), 32'h1);
        chk("b_first_line", bus_b.dispatch_encoder_line, 32'h55);
      end
      @(posedge clk);
      #1;
    end
    bus_b.src_dispatch_line_val = 1'b0;
    @(negedge clk);
    chk("b_sel_after_block", 32'(bus_b.dispatch_unit_sel), 32'd1);
    @(posedge clk);
    #1;

    // NUM_LINES=1, 3 units, random valid/readies, scoreboarded over 1000 lines.
    reset_all();
    acc = 0; popped = 0; cyc = 0; dones = 0; prev_pop = 1'b0;
    while (popped < 1000 && cyc < 20000) begin
      r = 3'($urandom_range(0, 7));
      bus_c.src_dispatch_line_val      = (acc < 1000) && ($urandom_range(0, 3) != 0);
      bus_c.src_dispatch_line          = DW'(acc);
      bus_c.encoder_dispatch_line_rdys = r;
      @(negedge clk);
      chk("c_done", 32'(bus_c.dispatch_block_done), 32'(prev_pop));
      if (bus_c.dispatch_block_done) dones++;
      chk("c_sel", 32'(bus_c.dispatch_unit_sel), 32'(acc % 3));
      chk("c_rdy", 32'(bus_c.dispatch_src_line_rdy), 32'((acc - popped) < 2));
      chk("c_valid", 32'(bus_c.dispatch_encoder_line_vals != 3'b000), 32'(acc > popped));
      exp_pop = 1'b0;
      if (acc > popped) begin
        chk("c_vals", 32'(bus_c.dispatch_encoder_line_vals), 32'(1 << (popped % 3)));
        chk("c_line", bus_c.dispatch_encoder_line, 32'(popped));
        exp_pop = r[popped % 3];
      end
      exp_acc = bus_c.src_dispatch_line_val && ((acc - popped) < 2);
      if (exp_pop) popped++;
      if (exp_acc) acc++;
      prev_pop = exp_pop;
      cyc++;
      @(posedge clk);
      #1;
    end
    chk("c_timeout", 32'(popped), 32'd1000);
    bus_c.src_dispatch_line_val      = 1'b0;
    bus_c.encoder_dispatch_line_rdys = 3'b111;
    @(negedge clk);
    chk("c_done_last", 32'(bus_c.dispatch_block_done), 32'(prev_pop));
    if (bus_c.dispatch_block_done) dones++;
    chk("c_done_count", 32'(dones), 32'd1000);
    chk("c_accepted", 32'(acc), 32'd1000);
    chk("c_empty", 32'(bus_c.dispatch_encoder_line_vals), 32'h0);
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs_encode_line_dispatch.md
Name: rs_encode_line_dispatch

Overview:
- Upstream stage of the multi-unit RS line encoder.
- Accepts a single val/rdy stream of DATA_W input lines and steers each RS block of NUM_LINES consecutive lines to one encoder unit.
- Units are used in strict round-robin order (unit 0, 1, …, NUM_RS_UNITS-1, 0, …), which is the order the downstream output mux drains them.
- Contains a 2-entry skid buffer so input ready is registered and never depends combinationally on encoder readies.

Parameters:
- DATA_W, 256, line width in bits.
- NUM_LINES, 8, lines per RS block; must be ≥1.
- NUM_RS_UNITS, 4, number of encoder units; must be ≥1.
- UNIT_SEL_W, $clog2(NUM_RS_UNITS) (min 1), width of the unit index.
- LINE_CNT_W, $clog2(NUM_LINES) (min 1), width of the line-in-block counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- src_dispatch_line_val  in  1  input line valid.
- src_dispatch_line  in  DATA_W  input line data.
- dispatch_src_line_rdy  out  1  input ready; registered.
- dispatch_encoder_line_vals  out  NUM_RS_UNITS  one-hot per-unit valid; all zero when idle.
- dispatch_encoder_line  out  DATA_W  line data, shared by all units.
- encoder_dispatch_line_rdys  in  NUM_RS_UNITS  per-unit ready.
- dispatch_block_done  out  1  one-cycle pulse when the last line of a block is accepted by its unit.
- dispatch_unit_sel  out  UNIT_SEL_W  unit that the next accepted input line will be tagged for.

Behaviour:
- Reset (async, rst=1):
  - Skid buffer emptied; line_cnt=0; in_unit=0.
  - dispatch_src_line_rdy=0 while rst is asserted; it becomes 1 on the first clk edge after rst deasserts.
  - dispatch_encoder_line_vals=0, dispatch_block_done=0, dispatch_encoder_line=0.
- Input side:
  - An input transfer occurs when src_dispatch_line_val && dispatch_src_line_rdy.
  - The line is written into the skid buffer tagged {unit=in_unit, last=(line_cnt==NUM_LINES-1)}.
  - On each transfer, line_cnt increments. When line_cnt==NUM_LINES-1 it wraps to 0 and in_unit advances, wrapping from NUM_RS_UNITS-1 to 0.
  - dispatch_src_line_rdy is registered and equals (occupancy after this cycle < 2).
- Skid buffer:
  - 2 entries, FIFO order.
  - A push and a pop in the same cycle are both allowed and leave occupancy unchanged.
  - Pop while empty cannot occur because the output valid is 0 when empty.
  - Push is never attempted while full because rdy is 0.
- Output side:
  - When the buffer is non-empty, the head entry is presented: dispatch_encoder_line = head data; dispatch_encoder_line_vals = one-hot(head.unit).
  - A pop occurs when encoder_dispatch_line_rdys[head.unit]=1. Readies of non-selected units are ignored.
  - Head-of-line blocking is intentional: a stalled unit stalls all units, preserving block order.
  - Valid must not drop, and data must not change, while the head is waiting.
- Latency: input accepted at edge N → line visible at output from cycle N+1. Full throughput is 1 line/cycle when the selected unit is continuously ready.
- dispatch_block_done is registered: it pulses 1 cycle after a pop whose head.last=1.
- Back-to-back blocks:
  - The first line of block k+1 may be in the buffer while the last line of block k is still at the head.
  - Tags are carried per entry, so no bubble is required at a unit switch.
- Degenerate sizes:
  - NUM_LINES=1: every line has last=1 and the unit advances on every line.
  - NUM_RS_UNITS=1: in_unit stays 0.
- Reset mid-block discards all buffered lines and restarts at unit 0, line 0. No partial-block recovery is provided.

Optional Feature:
- Macro: RS_DISPATCH_PERF_EN.
- When defined:
  - Adds output port dispatch_stall_cycles (32 bits), reset to 0.
  - It increments by 1 every cycle the buffer is non-empty and encoder_dispatch_line_rdys[head.unit]=0, and saturates at 32'hFFFFFFFF.
  - Adds output port dispatch_blocks_sent (32 bits), which increments on each dispatch_block_done pulse and wraps modulo 2^32.
- When undefined: neither port exists and no counter logic is instantiated. All other behaviour is identical.

Test Plan:
- Round-robin dispatch, throughput, and tagging (NUM_LINES=4, NUM_RS_UNITS=2):
  - Stimulus: 16 lines with data 0..15, input val=1 throughout, all unit readies=1.
  - Response: lines 0-3 go to vals=2'b01, 4-7 to 2'b10, 8-11 to 2'b01, 12-15 to 2'b10, each 1 cycle after acceptance.
  - Response: dispatch_block_done pulses 4 times, in the cycles after lines 3, 7, 11 and 15 are accepted by their unit.
  - Response: input rdy stays 1 throughout; 16 lines complete in 17 cycles.
- Head-of-line stall:
  - Stimulus: unit 1 ready=0 while line 4 is at the head and input val=1.
  - Response: buffer holds lines 4 and 5; rdy drops to 0 on the next cycle; the output holds vals=2'b10 with data=4 stable.
  - Response: after unit 1 ready=1, data 4 then 5 pop on consecutive cycles and rdy returns to 1.
- Ready isolation:
  - Stimulus: head tagged unit 0, unit 0 ready=0, unit 1 ready=1 for 5 cycles.
  - Response: no pop and no data change.
  - Response, with RS_DISPATCH_PERF_EN defined: dispatch_stall_cycles=5.
- Async reset mid-block:
  - Stimulus: assert rst between clk edges after 6 of 8 lines of a block (NUM_LINES=8) have been accepted.
  - Response: vals=0 and rdy=0 immediately, without waiting for a clock edge.
  - Response: after rst deasserts, the next accepted line is tagged unit 0 and dispatch_unit_sel=0.
- NUM_LINES=1, NUM_RS_UNITS=3 with random input valid and random unit readies:
  - Response: line i is dispatched to unit i mod 3.
  - Response: dispatch_block_done fires once per line.
  - Response: no line is lost or duplicated, checked by a scoreboard over 1000 lines.
